// File: rtl/gen_arb_rr_pkt.sv
// gen_arb_rr_pkt: packet-aware round-robin arbiter.
// A requester keeps the grant from its first beat until a beat flagged last
// is accepted; only then does the thermometer priority mask rotate.
// Optional feature macro: GEN_ARB_RR_MAX_BEATS_EN. When it is defined, a grant
// is force-released after MAX_BEATS accepted beats and beat_lim pulses.
//
// state | meaning
// IDLE  | no grant held; arbitrate among rqsts this cycle
// LOCK  | grant held by grnt_idx until eop (or beat-limit release)

module gen_arb_rr_pkt #(
    parameter int WID       = 4,
    parameter int IDX_W     = $clog2(WID),
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WID-1:0]   rqsts,
    input  logic [WID-1:0]   lasts,
    input  logic             out_rdy,
    output logic [WID-1:0]   grnts,
    output logic             grnt_vld,
    output logic [IDX_W-1:0] grnt_idx,
    output logic             beat_lim
);

    typedef enum logic {IDLE, LOCK} state_t;

    if (WID < 2 || MAX_BEATS < 1) begin : g_bad_param
        $error("gen_arb_rr_pkt: WID must be >= 2 and MAX_BEATS >= 1");
    end

    state_t             state_q, state_d;
    logic [WID-1:0]     grnts_q, grnts_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WID-1:0]     mask_q, mask_d;
    logic [WID-1:0]     pend;
    logic [IDX_W-1:0]   sel_idx;
    logic               acc;
    logic               eop;
    logic               force_rel;

    // Bits above the current holder become the high-priority group next round.
    function automatic logic [WID-1:0] thermo(input logic [WID-1:0] g);
        logic [WID-1:0] t;
        logic           run;
        run = 1'b0;
        for (int i = 0; i < WID; i++) begin
            t[i] = run;
            run  = run | g[i];
        end
        return t;
    endfunction

    assign grnts    = grnts_q;
    assign grnt_vld = |grnts_q;
    assign grnt_idx = idx_q;
    assign acc      = grnt_vld & rqsts[idx_q] & out_rdy;
    assign eop      = acc & lasts[idx_q];

    // Winner selection: lowest masked request, else lowest raw request.
    always_comb begin
        pend    = (|(rqsts & mask_q)) ? (rqsts & mask_q) : rqsts;
        sel_idx = '0;
        for (int i = WID - 1; i >= 0; i--) begin
            if (pend[i]) sel_idx = IDX_W'(i);
        end
    end

`ifdef GEN_ARB_RR_MAX_BEATS_EN
    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat_lim_q;

    assign force_rel = acc & ~lasts[idx_q] & (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign beat_lim  = beat_lim_q;

    // Beat counter: held at zero while idle so every new grant starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (acc)        cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter and release-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            beat_lim_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            beat_lim_q <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign beat_lim  = 1'b0;
`endif

    // Next-state: grant on any request in IDLE, release on eop or beat limit.
    always_comb begin
        state_d = state_q;
        grnts_d = grnts_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (|rqsts) begin
                    grnts_d          = '0;
                    grnts_d[sel_idx] = 1'b1;
                    idx_d            = sel_idx;
                    state_d          = LOCK;
                end
            end
            LOCK: begin
                if (eop || force_rel) begin
                    grnts_d = '0;
                    idx_d   = '0;
                    mask_d  = thermo(grnts_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grnts_q <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            grnts_q <= grnts_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_gen_arb_rr_pkt.sv
// Directed bench for gen_arb_rr_pkt (WID=4, MAX_BEATS=4).
module tb_gen_arb_rr_pkt;

    logic       clk;
    logic       rst_n;
    logic [3:0] rqsts;
    logic [3:0] lasts;
    logic       out_rdy;
    logic [3:0] grnts;
    logic       grnt_vld;
    logic [1:0] grnt_idx;
    logic       beat_lim;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [3:0] ls;
        logic       rdy;
        logic [3:0] eg;
        logic [1:0] ei;
        logic       ebl;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    gen_arb_rr_pkt #(.WID(4), .MAX_BEATS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rqsts    (rqsts),
        .lasts    (lasts),
        .out_rdy  (out_rdy),
        .grnts    (grnts),
        .grnt_vld (grnt_vld),
        .grnt_idx (grnt_idx),
        .beat_lim (beat_lim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic [3:0] eg, input logic [1:0] ei,
                           input logic ebl);
        chk({nm, ".grnts"}, 32'(grnts), 32'(eg));
        chk({nm, ".vld"},   32'(grnt_vld), 32'(|eg));
        chk({nm, ".idx"},   32'(grnt_idx), 32'(ei));
        chk({nm, ".blim"},  32'(beat_lim), 32'(ebl));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rqsts = '0; lasts = '0; out_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input bit rst, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rdy, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ebl, input string nm);
        vec_t v;
        v.rst = rst; v.rq = rq; v.ls = ls; v.rdy = rdy;
        v.eg = eg; v.ei = ei; v.ebl = ebl; v.nm = nm;
        vecs.push_back(v);
    endtask

    initial begin
        // t1: alternating single-beat packets from req0 and req2
        add(1, 4'b0101, 4'b0101, 1, 4'b0001, 2'd0, 0, "t1a");
        add(0, 4'b0101, 4'b0101, 1, 4'b0000, 2'd0, 0, "t1b");
        add(0, 4'b0101, 4'b0101, 1, 4'b0100, 2'd2, 0, "t1c");
        add(0, 4'b0101, 4'b0101, 1, 4'b0000, 2'd0, 0, "t1d");
        add(0, 4'b0101, 4'b0101, 1, 4'b0001, 2'd0, 0, "t1e");
        // t2: all four request, 3-beat packets, order 0,1,2,3,0
        for (int r = 0; r < 4; r++) begin
            logic [3:0] oh;
            oh = 4'b0001 << r;
            add(r == 0, 4'b1111, 4'b0000, 1, oh, 2'(r), 0, $sformatf("t2g%0d", r));
            add(0, 4'b1111, 4'b0000, 1, oh, 2'(r), 0, $sformatf("t2b1_%0d", r));
            add(0, 4'b1111, 4'b0000, 1, oh, 2'(r), 0, $sformatf("t2b2_%0d", r));
            add(0, 4'b1111, oh,      1, 4'b0000, 2'd0, 0, $sformatf("t2b3_%0d", r));
        end
        add(0, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 0, "t2wrap");
        // t3: req1 with back-pressure on its last beat, req3 waiting
        add(1, 4'b1010, 4'b0000, 1, 4'b0010, 2'd1, 0, "t3g");
        add(0, 4'b1010, 4'b0000, 1, 4'b0010, 2'd1, 0, "t3b1");
        add(0, 4'b1010, 4'b0010, 0, 4'b0010, 2'd1, 0, "t3s1");
        add(0, 4'b1010, 4'b0010, 0, 4'b0010, 2'd1, 0, "t3s2");
        add(0, 4'b1010, 4'b0010, 1, 4'b0000, 2'd0, 0, "t3eop");
        add(0, 4'b1010, 4'b0000, 1, 4'b1000, 2'd3, 0, "t3g3");
        add(0, 4'b1010, 4'b1000, 1, 4'b0000, 2'd0, 0, "t3eop3");
        // t4: req2 drops its request mid-packet while req0 waits
        add(1, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 0, "t4g");
        add(0, 4'b0101, 4'b0000, 1, 4'b0100, 2'd2, 0, "t4b1");
        add(0, 4'b0001, 4'b0100, 1, 4'b0100, 2'd2, 0, "t4gap1");
        add(0, 4'b0001, 4'b0100, 1, 4'b0100, 2'd2, 0, "t4gap2");
        add(0, 4'b0001, 4'b0100, 1, 4'b0100, 2'd2, 0, "t4gap3");
        add(0, 4'b0101, 4'b0100, 1, 4'b0000, 2'd0, 0, "t4eop");
        add(0, 4'b0001, 4'b0000, 1, 4'b0001, 2'd0, 0, "t4g0");
`ifdef GEN_ARB_RR_MAX_BEATS_EN
        // t6: req1 streams without last, limited to 4 beats
        add(1, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6g");
        add(0, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6b1");
        add(0, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6b2");
        add(0, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6b3");
        add(0, 4'b0110, 4'b0000, 1, 4'b0000, 2'd0, 1, "t6lim");
        add(0, 4'b0110, 4'b0000, 1, 4'b0100, 2'd2, 0, "t6g2");
        add(0, 4'b0110, 4'b0100, 1, 4'b0000, 2'd0, 0, "t6eop2");
        add(0, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6g1");
`else
        // t6: without the limit, req1 keeps streaming indefinitely
        add(1, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, "t6g");
        for (int b = 1; b <= 6; b++)
            add(0, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1, 0, $sformatf("t6b%0d", b));
`endif
        // t5 setup: req3 holds the grant
        add(1, 4'b1000, 4'b0000, 1, 4'b1000, 2'd3, 0, "t5g");
        add(0, 4'b1000, 4'b0000, 1, 4'b1000, 2'd3, 0, "t5hold");

        // Reset values
        rst_n = 1'b0; rqsts = '0; lasts = '0; out_rdy = 1'b0;
        #3;
        chk_all("rst", 4'b0000, 2'd0, 0);
        do_reset();
        chk_all("post_rst", 4'b0000, 2'd0, 0);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            rqsts = vecs[k].rq; lasts = vecs[k].ls; out_rdy = vecs[k].rdy;
            @(posedge clk); #1;
            chk_all(vecs[k].nm, vecs[k].eg, vecs[k].ei, vecs[k].ebl);
        end

        // t5: asynchronous reset mid-packet drops the grant at once
        #2 rst_n = 1'b0;
        #1 chk_all("t5async", 4'b0000, 2'd0, 0);
        rqsts = 4'b1001; lasts = 4'b0000; out_rdy = 1'b1;
        @(posedge clk); #1;
        chk_all("t5inrst", 4'b0000, 2'd0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("t5g0", 4'b0001, 2'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
